// File: rtl/i_fetch_buffered.sv
// Instruction-fetch stage: issues word fetches to a synchronous instruction memory and
// queues the responses in a small in-order buffer that decode drains via valid/ready.
module i_fetch_buffered #(
  parameter int                    INSTR_WIDTH     = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    FETCH_BUF_DEPTH = 4,
  localparam int                   CNT_WIDTH       = $clog2(FETCH_BUF_DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_IF_valid,
  input  logic                   i_ID_ready,
  output logic [INSTR_WIDTH-1:0] o_IF_instr,
  output logic [ADDR_WIDTH-1:0]  o_IF_program_cntr,
  output logic [ADDR_WIDTH-1:0]  o_IF_program_cntr_next,
  output logic [CNT_WIDTH-1:0]   o_buf_count
);

  localparam int                    PTR_WIDTH  = $clog2(FETCH_BUF_DEPTH);
  localparam logic [CNT_WIDTH:0]    DEPTH_C    = (CNT_WIDTH + 1)'(FETCH_BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  logic [INSTR_WIDTH-1:0] buf_instr_q [FETCH_BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  buf_pc_q    [FETCH_BUF_DEPTH];

  // Last presented head, so the data outputs stay put once the buffer empties.
  logic [INSTR_WIDTH-1:0] last_instr_q;
  logic [ADDR_WIDTH-1:0]  last_pc_q;
  logic [ADDR_WIDTH-1:0]  last_next_q;

  logic [CNT_WIDTH:0]     occupancy;
  logic                   issue;
  logic                   has_entry;
  logic                   push;
  logic                   pop;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0]  head_pc;

  // Credit check uses registered state only, so i_ID_ready never reaches o_imem_req.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CNT_WIDTH{1'b0}}, inflight_q};
    issue      = !i_reset && !i_redirect_valid && (occupancy < DEPTH_C);
    has_entry  = (count_q != '0);
    push       = !i_reset && !i_redirect_valid && inflight_q;
    pop        = !i_reset && !i_redirect_valid && has_entry && i_ID_ready;
    head_instr = buf_instr_q[rd_ptr_q];
    head_pc    = buf_pc_q[rd_ptr_q];
  end

  // NOTE: every next-state signal gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (i_redirect_valid) begin
      // Flush: drop the in-flight response and every queued entry.
      pc_d     = i_redirect_pc & ALIGN_MASK;
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + PC_STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
      last_next_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      last_instr_q  <= o_IF_instr;
      last_pc_q     <= o_IF_program_cntr;
      last_next_q   <= o_IF_program_cntr_next;
    end
  end

  // NOTE: buffer storage has no reset; count_q alone says which slots hold live entries.
  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= i_imem_rdata;
      buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign o_imem_req             = issue;
  assign o_imem_addr            = pc_q;
  assign o_IF_valid             = has_entry && !i_redirect_valid;
  assign o_IF_instr             = has_entry ? head_instr : last_instr_q;
  assign o_IF_program_cntr      = has_entry ? head_pc : last_pc_q;
  assign o_IF_program_cntr_next = has_entry ? (head_pc + PC_STEP) : last_next_q;
  assign o_buf_count            = count_q;

endmodule

// File: tb/tb_i_fetch_buffered.sv
// Directed bench for i_fetch_buffered: a table of per-cycle vectors for the default
// configuration, plus a hand-written wrap sequence on an 8-bit-address instance.
module tb_i_fetch_buffered;

  localparam logic [31:0] A = 32'hA000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        rst, redir, ready;
  logic [31:0] redir_pc;
  logic        req;
  logic [31:0] addr, rdata;
  logic        valid;
  logic [31:0] instr, pc, pc_next;
  logic [2:0]  cnt;

  i_fetch_buffered dut (
    .i_clk(clk), .i_reset(rst),
    .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_rdata(rdata),
    .o_IF_valid(valid), .i_ID_ready(ready),
    .o_IF_instr(instr), .o_IF_program_cntr(pc),
    .o_IF_program_cntr_next(pc_next), .o_buf_count(cnt)
  );

  // Synchronous memory: data for a request appears the following cycle.
  always @(posedge clk) rdata <= req ? (A | addr) : 32'hDEAD_BEEF;

  // ---------------- 8-bit-address instance ----------------
  logic        rst8, redir8;
  logic [7:0]  redir_pc8;
  logic        req8;
  logic [7:0]  addr8;
  logic [31:0] rdata8;
  logic        valid8;
  logic [31:0] instr8;
  logic [7:0]  pc8, pc_next8;
  logic [2:0]  cnt8;

  i_fetch_buffered #(.ADDR_WIDTH(8)) dut8 (
    .i_clk(clk), .i_reset(rst8),
    .i_redirect_valid(redir8), .i_redirect_pc(redir_pc8),
    .o_imem_req(req8), .o_imem_addr(addr8), .i_imem_rdata(rdata8),
    .o_IF_valid(valid8), .i_ID_ready(1'b1),
    .o_IF_instr(instr8), .o_IF_program_cntr(pc8),
    .o_IF_program_cntr_next(pc_next8), .o_buf_count(cnt8)
  );

  always @(posedge clk) rdata8 <= req8 ? (A | {24'd0, addr8}) : 32'hDEAD_BEEF;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int row    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        chk;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_next;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rs, input logic rd, input logic [31:0] rpc,
                             input logic rdy, input logic rq, input logic [31:0] ad,
                             input logic ck, input logic vl, input logic [31:0] p,
                             input logic [31:0] ins, input logic [31:0] nx,
                             input logic [2:0] c);
    vec_t r;
    r.rst = rs; r.redir = rd; r.rpc = rpc; r.rdy = rdy;
    r.exp_req = rq; r.exp_addr = ad; r.chk = ck; r.exp_valid = vl;
    r.exp_pc = p; r.exp_instr = ins; r.exp_next = nx; r.exp_cnt = c;
    return r;
  endfunction

  // Shorthand for a reset row: only o_imem_req=0 is checked.
  function automatic vec_t rr(input logic rdy);
    return v(1, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    rst = 1'b1; redir = 1'b0; redir_pc = '0; ready = 1'b0;
    rst8 = 1'b1; redir8 = 1'b0; redir_pc8 = '0;

    // Streaming at one instruction per cycle, pointer wrap included.
    vecs.push_back(rr(1));
    vecs.push_back(v(0,0,0,1, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h04, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h08, 1,1,32'h00,A|32'h00,   32'h04, 1));
    vecs.push_back(v(0,0,0,1, 1,32'h0C, 1,1,32'h04,A|32'h04,   32'h08, 1));
    vecs.push_back(v(0,0,0,1, 1,32'h10, 1,1,32'h08,A|32'h08,   32'h0C, 1));
    vecs.push_back(v(0,0,0,1, 1,32'h14, 1,1,32'h0C,A|32'h0C,   32'h10, 1));
    vecs.push_back(v(0,0,0,1, 1,32'h18, 1,1,32'h10,A|32'h10,   32'h14, 1));
    vecs.push_back(v(0,0,0,1, 1,32'h1C, 1,1,32'h14,A|32'h14,   32'h18, 1));
    // Backpressure: fill to 4, hold head, then drain in order.
    vecs.push_back(rr(0));
    vecs.push_back(v(0,0,0,0, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h04, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h08, 1,1,32'h00,A|32'h00,   32'h04, 1));
    vecs.push_back(v(0,0,0,0, 1,32'h0C, 1,1,32'h00,A|32'h00,   32'h04, 2));
    vecs.push_back(v(0,0,0,0, 0,32'h10, 1,1,32'h00,A|32'h00,   32'h04, 3));
    vecs.push_back(v(0,0,0,0, 0,32'h10, 1,1,32'h00,A|32'h00,   32'h04, 4));
    vecs.push_back(v(0,0,0,0, 0,32'h10, 1,1,32'h00,A|32'h00,   32'h04, 4));
    vecs.push_back(v(0,0,0,1, 0,32'h10, 1,1,32'h00,A|32'h00,   32'h04, 4));
    vecs.push_back(v(0,0,0,1, 1,32'h10, 1,1,32'h04,A|32'h04,   32'h08, 3));
    vecs.push_back(v(0,0,0,1, 1,32'h14, 1,1,32'h08,A|32'h08,   32'h0C, 2));
    vecs.push_back(v(0,0,0,1, 1,32'h18, 1,1,32'h0C,A|32'h0C,   32'h10, 2));
    vecs.push_back(v(0,0,0,1, 1,32'h1C, 1,1,32'h10,A|32'h10,   32'h14, 2));
    // Redirect to 0x103 with two entries queued and one in flight.
    vecs.push_back(rr(0));
    vecs.push_back(v(0,0,0,0, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h04, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h08, 1,1,32'h00,A|32'h00,   32'h04, 1));
    vecs.push_back(v(0,1,32'h103,1, 0,32'h0C, 1,0,32'h00,A|32'h00, 32'h04, 2));
    vecs.push_back(v(0,0,0,1, 1,32'h100, 1,0,32'h00,A|32'h00,  32'h04, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h104, 1,0,32'h00,A|32'h00,  32'h04, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h108, 1,1,32'h100,A|32'h100,32'h104,1));
    vecs.push_back(v(0,0,0,1, 1,32'h10C, 1,1,32'h104,A|32'h104,32'h108,1));
    // Redirect in the cycle the response for 0x8 returns.
    vecs.push_back(rr(1));
    vecs.push_back(v(0,0,0,1, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h04, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h08, 1,1,32'h00,A|32'h00,   32'h04, 1));
    vecs.push_back(v(0,1,32'h40,1, 0,32'h0C, 1,0,32'h04,A|32'h04, 32'h08, 1));
    vecs.push_back(v(0,0,0,1, 1,32'h40, 1,0,32'h04,A|32'h04,   32'h08, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h44, 1,0,32'h04,A|32'h04,   32'h08, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h48, 1,1,32'h40,A|32'h40,   32'h44, 1));
    // Reset pulsed with three entries queued.
    vecs.push_back(rr(0));
    vecs.push_back(v(0,0,0,0, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h04, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h08, 1,1,32'h00,A|32'h00,   32'h04, 1));
    vecs.push_back(v(0,0,0,0, 1,32'h0C, 1,1,32'h00,A|32'h00,   32'h04, 2));
    vecs.push_back(v(1,0,0,0, 0,32'h10, 1,1,32'h00,A|32'h00,   32'h04, 3));
    vecs.push_back(v(0,0,0,0, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h04, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,0,0,0, 1,32'h08, 1,1,32'h00,A|32'h00,   32'h04, 1));
    // Back-to-back redirects: the last target wins.
    vecs.push_back(rr(1));
    vecs.push_back(v(0,0,0,1, 1,32'h00, 1,0,32'h00,32'h0,      32'h00, 0));
    vecs.push_back(v(0,1,32'h200,1, 0,32'h04, 1,0,32'h00,32'h0,32'h00, 0));
    vecs.push_back(v(0,1,32'h300,1, 0,32'h200,1,0,32'h00,32'h0,32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h300, 1,0,32'h00,32'h0,     32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h304, 1,0,32'h00,32'h0,     32'h00, 0));
    vecs.push_back(v(0,0,0,1, 1,32'h308, 1,1,32'h300,A|32'h300,32'h304,1));

    for (int i = 0; i < vecs.size(); i++) begin
      row      = i;
      rst      = vecs[i].rst;
      redir    = vecs[i].redir;
      redir_pc = vecs[i].rpc;
      ready    = vecs[i].rdy;
      @(negedge clk);
      check("imem_req", {31'd0, req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) check("imem_addr", addr, vecs[i].exp_addr);
      if (vecs[i].chk) begin
        check("IF_valid", {31'd0, valid}, {31'd0, vecs[i].exp_valid});
        check("IF_pc", pc, vecs[i].exp_pc);
        check("IF_instr", instr, vecs[i].exp_instr);
        check("IF_pc_next", pc_next, vecs[i].exp_next);
        check("buf_count", {29'd0, cnt}, {29'd0, vecs[i].exp_cnt});
      end
      @(posedge clk); #1;
    end

    // 8-bit address space: redirect to 0xFE (aligned to 0xFC), PC wraps to 0x00.
    row = 1000;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0; redir8 = 1'b1; redir_pc8 = 8'hFE;
    @(negedge clk);
    check("w8_req_during_redirect", {31'd0, req8}, 32'd0);
    @(posedge clk); #1;
    redir8 = 1'b0;
    row = 1001;
    @(negedge clk);
    check("w8_req", {31'd0, req8}, 32'd1);
    check("w8_addr_target", {24'd0, addr8}, 32'h0000_00FC);
    @(posedge clk); #1;
    row = 1002;
    @(negedge clk);
    check("w8_addr_wrap", {24'd0, addr8}, 32'h0000_0000);
    check("w8_valid_early", {31'd0, valid8}, 32'd0);
    @(posedge clk); #1;
    row = 1003;
    @(negedge clk);
    check("w8_valid", {31'd0, valid8}, 32'd1);
    check("w8_pc", {24'd0, pc8}, 32'h0000_00FC);
    check("w8_pc_next_wrap", {24'd0, pc_next8}, 32'h0000_0000);
    check("w8_instr", instr8, 32'hA000_00FC);
    check("w8_count", {29'd0, cnt8}, 32'd1);
    @(posedge clk); #1;
    row = 1004;
    @(negedge clk);
    check("w8_pc_after_wrap", {24'd0, pc8}, 32'h0000_0000);
    check("w8_pc_next_after_wrap", {24'd0, pc_next8}, 32'h0000_0004);
    check("w8_instr_after_wrap", instr8, 32'hA000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
